cic_interp_integrator: RTL

- Interpolating counterpart of the decimating comb stage; together they form the CIC pair for the up-sampling direction.
- Accepts low-rate samples over a valid/ready handshake and expands each one by factor R with zero-stuffing.
- Passes the expanded stream through a STAGES-deep integrator cascade and emits R high-rate samples per input, with downstream backpressure.

---
 rtl/cic_pkg.sv | 20 ++
 rtl/cic_integrator_stage.sv | 31 +++
 rtl/cic_interp_integrator.sv | 123 ++++++++++++
 3 files changed

// File: rtl/cic_pkg.sv
// Shared definitions for the CIC interpolator integrator section.
//   state_e   : sequencing state of the interpolator (IDLE / EMIT)
//   LOG2R     : log2 of the default interpolation ratio
//   out_bits(): accumulator width that holds the full CIC gain without loss
package cic_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  localparam int R_DEFAULT = 4;
  localparam int LOG2R     = $clog2(R_DEFAULT);

  // Each integrator stage can grow the signal by log2(R) bits.
  function automatic int out_bits(input int bits, input int stages, input int r);
    return bits + stages * $clog2(r);
  endfunction

endpackage

// File: rtl/cic_integrator_stage.sv
// One integrator of the CIC cascade.
//   clk, rst : clock, asynchronous active-high reset
//   step_i   : advance the accumulator this cycle
//   din_i    : value added on a step
//   acc_d_o  : next accumulator value (combinational, acc + din)
//   acc_q_o  : registered accumulator value
module cic_integrator_stage
  import cic_pkg::*;
#(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] acc_d_o,
  output logic [W-1:0] acc_q_o
);

  logic [W-1:0] acc_q;

  // Modular add: wrap-around is cancelled by the comb section.
  assign acc_d_o = acc_q + din_i;
  assign acc_q_o = acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         acc_q <= '0;
    else if (step_i) acc_q <= acc_d_o;
  end

endmodule

// File: rtl/cic_interp_integrator.sv
// CIC interpolator integrator section: takes low-rate samples over
// valid/ready, zero-stuffs each by R and runs them through a STAGES-deep
// integrator cascade, producing R high-rate samples per input.
//   clk, rst               : clock, asynchronous active-high reset
//   stream_in/in_valid/in_ready    : low-rate input handshake
//   stream_out/out_valid/out_ready : high-rate output handshake
// Build option: CIC_GAIN_NORM_EN shifts the output right by
// (STAGES-1)*log2(R) to remove the cascade gain (port width unchanged).
//
// state | meaning
// IDLE  | no sample held, ready for input
// EMIT  | sample held in x_q, phase p_q walks 0..R-1
module cic_interp_integrator
  import cic_pkg::*;
#(
  parameter int R        = 4,
  parameter int STAGES   = 2,
  parameter int BITS     = 10,
  parameter int OUT_BITS = out_bits(BITS, STAGES, R)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BITS-1:0]     stream_in,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [OUT_BITS-1:0] stream_out,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int PW = $clog2(R);

  state_e                state_q, state_d;
  logic [PW-1:0]         p_q, p_d;
  logic [OUT_BITS-1:0]   x_q, x_d;
  logic                  out_valid_q, out_valid_d;
  logic                  step, last_phase, accept;
  logic [OUT_BITS-1:0]   feed;

  logic [OUT_BITS-1:0]               acc_next [STAGES];
  logic [STAGES-1:0][OUT_BITS-1:0]   acc_reg;
  logic                              unused_acc;

  assign last_phase = (p_q == PW'(R-1));
  assign accept     = in_valid && in_ready;
  // Zero-stuffing: the held sample enters the cascade only on phase 0.
  assign feed       = (p_q == '0) ? x_q : '0;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state. An accept on the last-phase step keeps us in EMIT.
  always_comb begin
    state_d = state_q;
    if (accept)                  state_d = EMIT;
    else if (step && last_phase) state_d = IDLE;
  end

  // FSM: outputs. in_ready during the last step gives bubble-free bursts.
  always_comb begin
    step     = (state_q == EMIT) && (!out_valid_q || out_ready);
    in_ready = (state_q == IDLE) || (step && last_phase);
  end

  always_comb begin
    p_d = p_q;
    if (accept)    p_d = '0;
    else if (step) p_d = last_phase ? '0 : p_q + PW'(1);

    x_d = accept ? {{(OUT_BITS-BITS){stream_in[BITS-1]}}, stream_in} : x_q;

    out_valid_d = out_valid_q;
    if (step)           out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q         <= '0;
      x_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      p_q         <= p_d;
      x_q         <= x_d;
      out_valid_q <= out_valid_d;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [OUT_BITS-1:0] din;
    if (k == 0) begin : g_first
      assign din = feed;
    end else begin : g_rest
      assign din = acc_next[k-1];
    end
    cic_integrator_stage #(.W(OUT_BITS)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .step_i  (step),
      .din_i   (din),
      .acc_d_o (acc_next[k]),
      .acc_q_o (acc_reg[k])
    );
  end

  // Only the last stage's register and the inner next-values are consumed.
  assign unused_acc = ^{acc_reg, acc_next[STAGES-1]};

  // The last accumulator only updates on a step, so it already is the
  // registered output: it holds under stall and clears on reset.
`ifdef CIC_GAIN_NORM_EN
  localparam int NORM_SHIFT = (STAGES-1) * PW;
  assign stream_out = $signed(acc_reg[STAGES-1]) >>> NORM_SHIFT;
`else
  assign stream_out = acc_reg[STAGES-1];
`endif

  assign out_valid = out_valid_q;

endmodule
